pwm_led_bus: RTL
================

PWM_LED_BUS -- requirements
Module: pwm_led_bus

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of output channels, legal range 1..32.
REQ-002 SHALL have parameter CNT_W, default 16, width of the period counter, PERIOD register and DUTY registers, legal range 4..16.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bus, naive_bus slave modport: rd_req, rd_gnt, rd_addr, rd_data, wr_req, wr_gnt, wr_addr, wr_data, wr_be (4 bits).
REQ-006 SHALL have port led, output, N_CH bits: per-channel output, registered.

Function
REQ-007 Register map, byte offsets in bus address bits [7:0]:
- 0x00 CTRL: bit0 EN; bits[23:8] PRESC.
- 0x04 PERIOD
- 0x08 MODE: bit i = 1 selects PWM on channel i, 0 selects DIRECT.
- 0x0C DIRECT: bit i drives channel i when not in PWM mode.
- 0x10 STATUS: bit0 WRAP, sticky.
- 0x20+4*i DUTY[i], i = 0..N_CH-1.
- The integrating top sets the router mask to 0x0000_00ff.
REQ-008 Handshake:
- rd_gnt = rd_req and wr_gnt = wr_req combinationally; the block never stalls.
- rd_data is registered and valid the cycle after rd_gnt.
- rd_data holds its last value when there is no read.
REQ-009 Write byte lanes: each byte lane k of wr_data SHALL update the addressed register only when wr_be[k]=1. Register bits above the field width are ignored on write and read as 0.
REQ-010 Unmapped offsets, and DUTY indices >= N_CH: reads return 0, writes are ignored, and the access is still granted.
REQ-011 Read and write in the same cycle: both are granted; the read returns the value before the write.
REQ-012 Prescaler: pre_cnt counts 0..PRESC while EN=1. A tick is produced when pre_cnt==PRESC, and pre_cnt then wraps to 0. PRESC=0 gives a tick every cycle.
REQ-013 Counter: cnt (CNT_W bits) advances only on a tick while EN=1.
- If cnt==PERIOD_act at the tick: cnt goes to 0, PERIOD_act loads the PERIOD register, each DUTY_act[i] loads DUTY[i], and WRAP sets.
- Otherwise cnt increments.
REQ-014 Shadowing: register writes to PERIOD and DUTY SHALL NOT affect the running period. They take effect only at the wrap in REQ-013, or on every cycle while EN=0.
REQ-015 PWM compare: pwm[i] = (cnt < DUTY_act[i]). As a result:
- DUTY_act=0 gives constant 0.
- DUTY_act > PERIOD_act gives constant 1.
- PERIOD_act=0 gives one count per period.
REQ-016 led[i] SHALL register MODE[i] ? pwm[i] : DIRECT[i], giving one cycle of latency from cnt or register to pin.
REQ-017 While EN=0: pre_cnt=0, cnt=0, pwm[i]=0. DIRECT channels are unaffected.
REQ-018 Clearing EN mid-period SHALL zero cnt and pre_cnt on the next edge. Setting EN restarts at cnt=0 with freshly loaded active values.
REQ-019 STATUS.WRAP is cleared by writing 1 to bit0 with wr_be[0]=1. If a wrap and a clear occur in the same cycle, set wins.
REQ-020 Reads of DUTY and PERIOD SHALL return the register (shadow) value, not the active value.

Reset
REQ-021 On rst_n low, immediately and independent of clk, all of the following SHALL go to 0: every register, every active copy, pre_cnt, cnt, WRAP, rd_data and led.
REQ-022 Accesses that coincide with reset SHALL be lost. The first access after rst_n deasserts SHALL behave normally.

Verification (N_CH=4, CNT_W=8)
REQ-023 Reset then read every map offset -> all return 0x00000000; led=4'b0000.
REQ-024 Write PERIOD=9, DUTY[0]=3, MODE=0x1, then CTRL=0x00000001 -> led[0] high for exactly 3 of every 10 cycles, repeating; led[3:1] stay 0.
REQ-025 Running as in REQ-024, write DUTY[0]=7 when cnt=5 -> the current period keeps 3 high cycles; the next period and after have 7 high cycles; an immediate read returns 7.
REQ-026 DUTY[1]=0 and DUTY[2]=0xFF with PERIOD=9, MODE=0x6 -> led[1] is constant 0 and led[2] is constant 1 after the first wrap.
REQ-027 CTRL write of 0x00123401 with wr_be=4'b0001 -> EN=1 and PRESC stays 0, so CTRL reads 0x00000001. Then write wr_be=4'b0010 -> PRESC=0x34 and a tick every 53 cycles. Next, write STATUS=1 in the cycle of a wrap -> WRAP reads 1.
REQ-028 Assert rst_n low asynchronously mid-period with led[0]=1 -> led goes to 0 before the next clk edge, and all registers read 0 after release.

Source files
------------

// File: rtl/pwm_led_bus_if.sv
// Request/grant register bus. Reads return data one cycle after the grant;
// writes carry a 4-bit byte-lane enable.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/pwm_led_bus.sv
// Multi-channel PWM / direct LED driver with a bus-mapped register file.
// PERIOD and DUTY are shadowed: the running period uses active copies that
// reload at each counter wrap, or continuously while the block is disabled.
module pwm_led_bus #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  naive_bus.slave         bus,
  output logic [N_CH-1:0] led
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PERIOD = 8'h04;
  localparam logic [7:0] A_MODE   = 8'h08;
  localparam logic [7:0] A_DIRECT = 8'h0C;
  localparam logic [7:0] A_STATUS = 8'h10;

  logic             en_q, en_d;
  logic [15:0]      presc_q, presc_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  direct_q, direct_d;
  logic [CNT_W-1:0] duty_q [N_CH];
  logic [CNT_W-1:0] duty_d [N_CH];
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] duty_act_q [N_CH];
  logic [CNT_W-1:0] duty_act_d [N_CH];
  logic [15:0]      pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [N_CH-1:0]  led_q, led_d;

  logic [31:0]      rd_val;
  logic [N_CH-1:0]  pwm;
  logic             tick;
  logic             wrap_evt;
  logic [7:0]       rd_off;
  logic [7:0]       wr_off;
  logic             unused_addr_bits;

  // Merge a write into an existing word, one byte lane at a time.
  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = be[k] ? wdata[8*k +: 8] : old_val[8*k +: 8];
    end
    return r;
  endfunction

  // The block never stalls, so grants simply echo the requests.
  assign bus.rd_gnt  = bus.rd_req;
  assign bus.wr_gnt  = bus.wr_req;
  assign bus.rd_data = rd_data_q;
  assign led         = led_q;

  // Only the low address byte is decoded; the router masks the rest.
  assign rd_off           = bus.rd_addr[7:0];
  assign wr_off           = bus.wr_addr[7:0];
  assign unused_addr_bits = ^{bus.rd_addr[31:8], bus.wr_addr[31:8]};

  // Read mux over the shadow registers; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    case (rd_off)
      A_CTRL:   rd_val = {8'h00, presc_q, 7'h00, en_q};
      A_PERIOD: rd_val = 32'(period_q);
      A_MODE:   rd_val = 32'(mode_q);
      A_DIRECT: rd_val = 32'(direct_q);
      A_STATUS: rd_val = {31'h0, wrap_q};
      default:  ;
    endcase
    for (int i = 0; i < N_CH; i++) begin
      if (rd_off == 8'(32 + 4*i)) rd_val = 32'(duty_q[i]);
    end
  end

  // Prescaler and period counter; active copies track the shadows while disabled.
  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    tick         = 1'b0;
    wrap_evt     = 1'b0;
    if (!en_q) begin
      pre_cnt_d    = '0;
      cnt_d        = '0;
      period_act_d = period_q;
      duty_act_d   = duty_q;
    end else begin
      tick      = (pre_cnt_q == presc_q);
      pre_cnt_d = tick ? 16'h0000 : pre_cnt_q + 16'd1;
      if (tick) begin
        if (cnt_q == period_act_q) begin
          cnt_d        = '0;
          period_act_d = period_q;
          duty_act_d   = duty_q;
          wrap_evt     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Register writes with byte lanes; a wrap beats a simultaneous WRAP clear.
  always_comb begin
    en_d     = en_q;
    presc_d  = presc_q;
    period_d = period_q;
    mode_d   = mode_q;
    direct_d = direct_q;
    duty_d   = duty_q;
    wrap_d   = wrap_q;
    if (bus.wr_req) begin
      case (wr_off)
        A_CTRL: begin
          en_d          = bus.wr_be[0] ? bus.wr_data[0]     : en_q;
          presc_d[7:0]  = bus.wr_be[1] ? bus.wr_data[15:8]  : presc_q[7:0];
          presc_d[15:8] = bus.wr_be[2] ? bus.wr_data[23:16] : presc_q[15:8];
        end
        A_PERIOD: period_d = CNT_W'(merge_be(32'(period_q), bus.wr_data, bus.wr_be));
        A_MODE:   mode_d   = N_CH'(merge_be(32'(mode_q), bus.wr_data, bus.wr_be));
        A_DIRECT: direct_d = N_CH'(merge_be(32'(direct_q), bus.wr_data, bus.wr_be));
        A_STATUS: if (bus.wr_be[0] && bus.wr_data[0]) wrap_d = 1'b0;
        default:  ;
      endcase
      for (int i = 0; i < N_CH; i++) begin
        if (wr_off == 8'(32 + 4*i)) begin
          duty_d[i] = CNT_W'(merge_be(32'(duty_q[i]), bus.wr_data, bus.wr_be));
        end
      end
    end
    if (wrap_evt) wrap_d = 1'b1;
  end

  // PWM compare, per-channel output select and read data hold.
  always_comb begin
    pwm   = '0;
    led_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      pwm[i]   = en_q && (cnt_q < duty_act_q[i]);
      led_d[i] = mode_q[i] ? pwm[i] : direct_q[i];
    end
    rd_data_d = bus.rd_req ? rd_val : rd_data_q;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      presc_q      <= '0;
      period_q     <= '0;
      mode_q       <= '0;
      direct_q     <= '0;
      wrap_q       <= 1'b0;
      period_act_q <= '0;
      pre_cnt_q    <= '0;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      led_q        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i]     <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      en_q         <= en_d;
      presc_q      <= presc_d;
      period_q     <= period_d;
      mode_q       <= mode_d;
      direct_q     <= direct_d;
      wrap_q       <= wrap_d;
      period_act_q <= period_act_d;
      pre_cnt_q    <= pre_cnt_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      led_q        <= led_d;
      duty_q       <= duty_d;
      duty_act_q   <= duty_act_d;
    end
  end

endmodule
